// File: rtl/commit_trace_tx_if.sv
// Trace word stream: the transmitter drives valid/data, the sink answers with ready.
interface commit_trace_tx_if;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: captures commit events into a FIFO and serializes
// each one as a record of 16-bit words, ending with a count summary after halt.
module commit_trace_tx #(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wr,
    input  logic [2:0]        reg_wr_id,
    input  logic [15:0]       reg_wr_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              halt,
    input  logic              dc_req,
    input  logic              dc_hit,
    input  logic              ic_req,
    input  logic              ic_hit,
    commit_trace_tx_if.master tx,
    output logic              stall_req,
    output logic              overflow,
    output logic              done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        halt;
        logic [2:0]  id;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } entry_t;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_REGD, S_ADDR, S_DATA, S_SUM, S_DONE} state_t;

    entry_t            fifo_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cap_en_q, cap_en_d;
    logic              overflow_q, overflow_d;
    // Summary order: inst, dc_hit, ic_hit, dc_req, ic_req
    logic [4:0][15:0]  stat_q, stat_d;
    state_t            state_q, state_d;
    logic [2:0]        sum_idx_q, sum_idx_d;
    logic              tx_valid_q, tx_valid_d;
    logic [15:0]       tx_data_q, tx_data_d;
    logic              done_q, done_d;

    logic   push, full, push_ok, pop, hs;
    logic [4:0] inc;
    entry_t push_e, head, nxt;
    state_t nstate;

    function automatic logic [15:0] hdr_word(entry_t e);
        return {4'hA, e.reg_wr, e.mem_rd, e.mem_wr, e.halt, e.id, 5'b0};
    endfunction

    // Word kind that follows s within e's record; S_IDLE marks end of record.
    function automatic state_t after_word(state_t s, entry_t e);
        state_t n;
        n = S_IDLE;
        case (s)
            S_HDR:   n = e.reg_wr ? S_REGD : (e.mem_rd | e.mem_wr) ? S_ADDR : e.halt ? S_SUM : S_IDLE;
            S_REGD:  n = (e.mem_rd | e.mem_wr) ? S_ADDR : e.halt ? S_SUM : S_IDLE;
            S_ADDR:  n = S_DATA;
            S_DATA:  n = e.halt ? S_SUM : S_IDLE;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    always_comb begin
        push    = cap_en_q & (reg_wr | mem_rd | mem_wr | halt);
        full    = (cnt_q == CW'(DEPTH));
        push_ok = push & ~full;
        hs      = tx_valid_q & tx.tx_ready;
        push_e  = '{reg_wr: reg_wr, mem_rd: mem_rd & ~mem_wr, mem_wr: mem_wr, halt: halt,
                    id: reg_wr ? reg_wr_id : 3'd0, rdata: reg_wr_data, addr: mem_addr,
                    mdata: mem_wr ? mem_wdata : mem_rdata};
        head    = fifo_q[rd_ptr_q];
        nxt     = fifo_q[rd_ptr_q + AW'(1)];
        nstate  = after_word(state_q, head);
        inc     = {ic_req, dc_req, ic_hit, dc_hit, halt | reg_wr | mem_wr};

        pop        = 1'b0;
        state_d    = state_q;
        sum_idx_d  = sum_idx_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = done_q;
        stat_d     = stat_q;

        for (int i = 0; i < 5; i++)
            if (cap_en_q && inc[i] && stat_q[i] != 16'hFFFF)
                stat_d[i] = stat_q[i] + 16'd1;

        case (state_q)
            S_IDLE: if (cnt_q != '0) begin
                state_d    = S_HDR;
                tx_valid_d = 1'b1;
                tx_data_d  = hdr_word(head);
            end
            S_SUM: if (hs) begin
                if (sum_idx_q == 3'd4) begin
                    pop        = 1'b1;
                    state_d    = S_DONE;
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    sum_idx_d = sum_idx_q + 3'd1;
                    tx_data_d = stat_q[sum_idx_q + 3'd1];
                end
            end
            S_DONE: ;
            default: if (hs) begin
                state_d = nstate;
                case (nstate)
                    S_REGD: tx_data_d = head.rdata;
                    S_ADDR: tx_data_d = head.addr;
                    S_DATA: tx_data_d = head.mdata;
                    S_SUM: begin
                        sum_idx_d = 3'd0;
                        tx_data_d = stat_q[0];
                    end
                    default: begin
                        // Last word: chain straight into the next header when one is queued.
                        pop = 1'b1;
                        if (cnt_q > CW'(1)) begin
                            state_d   = S_HDR;
                            tx_data_d = hdr_word(nxt);
                        end else begin
                            tx_valid_d = 1'b0;
                        end
                    end
                endcase
            end
        endcase

        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d      = cnt_q + CW'(push_ok) - CW'(pop);
        cap_en_d   = cap_en_q & ~(push_ok & halt);
        overflow_d = overflow_q | (push & full);
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= push_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            cap_en_q   <= 1'b1;
            overflow_q <= 1'b0;
            stat_q     <= '0;
            state_q    <= S_IDLE;
            sum_idx_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            cap_en_q   <= cap_en_d;
            overflow_q <= overflow_d;
            stat_q     <= stat_d;
            state_q    <= state_d;
            sum_idx_q  <= sum_idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign stall_req   = (cnt_q >= CW'(DEPTH - 1));
    assign overflow    = overflow_q;
    assign done        = done_q;
endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx: a record-level model predicts the word stream,
// a monitor checks every handshaken word and backpressure stability.
module tb_commit_trace_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 0, mem_rd = 0, mem_wr = 0, halt = 0;
    logic [2:0]  reg_wr_id = '0;
    logic [15:0] reg_wr_data = '0, mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
    logic        dc_req = 0, dc_hit = 0, ic_req = 0, ic_hit = 0;
    logic        stall_req, overflow, done;

    commit_trace_tx_if tx_if ();

    commit_trace_tx #(.DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_wr_id(reg_wr_id),
        .reg_wr_data(reg_wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt), .dc_req(dc_req),
        .dc_hit(dc_hit), .ic_req(ic_req), .ic_hit(ic_hit), .tx(tx_if.master),
        .stall_req(stall_req), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    int          rdy_mode = 1;        // 0: never ready, 1: always, 2: random
    logic [15:0] exp_q[$];
    bit          cap_m = 1'b1;
    int          st_m[5];             // inst, dc_hit, ic_hit, dc_req, ic_req
    bit          drop_next = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic sat_inc(input int i);
        if (st_m[i] < 65535) st_m[i]++;
    endtask

    // One commit cycle; the model applies the capture rules at the same edge.
    task automatic ev(input bit rw, input logic [2:0] id, input logic [15:0] rdat,
                      input bit mrd, input bit mwr, input logic [15:0] addr,
                      input logic [15:0] wdat, input logic [15:0] ldat, input bit hlt,
                      input logic [3:0] stb);
        bit pushed;
        int h;
        reg_wr = rw; reg_wr_id = id; reg_wr_data = rdat; mem_rd = mrd; mem_wr = mwr;
        mem_addr = addr; mem_wdata = wdat; mem_rdata = ldat; halt = hlt;
        {ic_hit, ic_req, dc_hit, dc_req} = stb;
        @(posedge clk);
        if (cap_m) begin
            pushed = (rw || mrd || mwr || hlt) && !drop_next;
            if (rw || mwr || hlt) sat_inc(0);
            if (stb[1]) sat_inc(1);
            if (stb[3]) sat_inc(2);
            if (stb[0]) sat_inc(3);
            if (stb[2]) sat_inc(4);
            if (pushed) begin
                h = 'hA000 + (rw ? 2048 : 0) + ((mrd && !mwr) ? 1024 : 0) + (mwr ? 512 : 0)
                    + (hlt ? 256 : 0) + (rw ? int'(id) * 32 : 0);
                exp_q.push_back(16'(h));
                if (rw) exp_q.push_back(rdat);
                if (mrd || mwr) begin
                    exp_q.push_back(addr);
                    exp_q.push_back(mwr ? wdat : ldat);
                end
                if (hlt) begin
                    for (int i = 0; i < 5; i++) exp_q.push_back(16'(st_m[i]));
                    cap_m = 1'b0;
                end
            end
        end
        drop_next = 1'b0;
        #1;
        {reg_wr, mem_rd, mem_wr, halt, dc_req, dc_hit, ic_req, ic_hit} = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {reg_wr, mem_rd, mem_wr, halt, dc_req, dc_hit, ic_req, ic_hit} = '0;
        exp_q.delete();
        cap_m = 1'b1;
        for (int i = 0; i < 5; i++) st_m[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Sink side
    initial begin
        tx_if.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       tx_if.tx_ready = 1'b0;
                1:       tx_if.tx_ready = 1'b1;
                default: tx_if.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every accepted word against the model, plus hold-under-stall
    initial begin
        bit          prev_stall;
        logic [15:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_stall = 1'b0;
            else begin
                if (prev_stall) begin
                    check("hold_valid", tx_if.tx_valid, 1);
                    check("hold_data", tx_if.tx_data, prev_data);
                end
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $error("FAIL extra_word: got %0h expected none", tx_if.tx_data);
                    end else check("word", tx_if.tx_data, exp_q.pop_front());
                end
                prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
                prev_data  = tx_if.tx_data;
            end
        end
    end

    initial begin
        bit rw, mrd, mwr;
        do_reset();
        @(negedge clk);
        check("rst_valid", tx_if.tx_valid, 0);
        check("rst_data", tx_if.tx_data, 0);
        check("rst_stall", stall_req, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", done, 0);

        // Register write: latency and word order
        ev(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("t1_v0", tx_if.tx_valid, 0);
        @(negedge clk); check("t1_v1", tx_if.tx_valid, 1); check("t1_hdr", tx_if.tx_data, 16'hA860);
        @(negedge clk); check("t1_v2", tx_if.tx_valid, 1); check("t1_dat", tx_if.tx_data, 16'h1234);
        @(negedge clk); check("t1_v3", tx_if.tx_valid, 0);

        // Store then load, back to back
        ev(0, 3'd0, 16'h0, 0, 1, 16'h0040, 16'hBEEF, 16'h0, 0, 0);
        ev(1, 3'd2, 16'h0055, 1, 0, 16'h0010, 16'h0, 16'h0055, 0, 0);
        drain("drain_basic");
        @(negedge clk); check("basic_idle", tx_if.tx_valid, 0);

        // Backpressure on a header
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        ev(1, 3'd5, 16'hCAFE, 1, 0, 16'h1230, 16'h0, 16'hCAFE, 0, 0);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", tx_if.tx_valid, 1);
            check("bp_hdr", tx_if.tx_data, 16'hACA0);
        end
        rdy_mode = 2;
        drain("drain_bp");

        // Fill to overflow with the sink stalled
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) drop_next = 1'b1;
            ev(1, 3'(k), 16'h0100 + 16'(k), 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("fill_stall", stall_req, (k >= 7) ? 1 : 0);
            check("fill_ovf", overflow, (k == 9) ? 1 : 0);
        end
        rdy_mode = 1;
        drain("drain_ovf");
        @(negedge clk);
        check("ovf_sticky", overflow, 1);
        check("ovf_stall_clr", stall_req, 0);

        // Random commits, honouring stall_req, random sink readiness
        rdy_mode = 2;
        for (int n = 0; n < 80; n++) begin
            if (stall_req) ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'($urandom));
            else begin
                rw  = 1'($urandom); mrd = 1'($urandom); mwr = 1'($urandom);
                ev(rw, 3'($urandom), 16'($urandom), mrd, mwr, 16'($urandom),
                   16'($urandom), 16'($urandom), 0, 4'($urandom));
            end
        end
        drain("drain_rand");

        // Halt summary from a fresh reset
        do_reset();
        rdy_mode = 1;
        @(negedge clk);
        ev(1, 3'd1, 16'h1111, 0, 0, 0, 0, 0, 0, 4'b0001);
        ev(1, 3'd4, 16'h2222, 0, 0, 0, 0, 0, 0, 4'b0001);
        ev(1, 3'd7, 16'h3333, 0, 0, 0, 0, 0, 0, 4'b0010);
        ev(0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 1, 0);
        check("halt_done0", done, 0);
        ev(1, 3'd2, 16'h9999, 0, 0, 0, 0, 0, 0, 4'b0011);
        ev(0, 3'd0, 16'h0, 0, 1, 16'h0004, 16'h7777, 0, 0, 0);
        drain("drain_halt");
        @(negedge clk);
        check("halt_done", done, 1);
        check("halt_valid", tx_if.tx_valid, 0);

        // Reset in the middle of a record
        do_reset();
        @(negedge clk);
        ev(1, 3'd6, 16'hABCD, 0, 0, 0, 0, 0, 0, 0);
        ev(0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #3;
        check("pre_rst_valid", tx_if.tx_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_valid", tx_if.tx_valid, 0);
        check("async_data", tx_if.tx_data, 0);
        do_reset();
        repeat (6) @(negedge clk);
        check("post_rst_done", done, 0);
        check("post_rst_valid", tx_if.tx_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
